// File: rtl/nvdla_dbb_tcdm_bridge.sv
`default_nettype none
// ============================================================================
// nvdla_dbb_tcdm_bridge : splits one wide DBB beat across MP 32-bit TCDM ports
// in DW/(32*MP) slices and reassembles read words into a single response beat.
// Rev 1.0
// ============================================================================
module nvdla_dbb_tcdm_bridge #(
  parameter int DW    = 512,
  parameter int MP    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DW-1:0]     req_data_i,
  input  logic [DW/8-1:0]   req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_data_o,
  output logic              wr_done_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [MP-1:0]     tcdm_req_o,
  input  logic [MP-1:0]     tcdm_gnt_i,
  output logic [MP*32-1:0]  tcdm_add_o,
  output logic [MP-1:0]     tcdm_wen_o,
  output logic [MP*4-1:0]   tcdm_be_o,
  output logic [MP*32-1:0]  tcdm_data_o,
  input  logic [MP*32-1:0]  tcdm_r_data_i,
  input  logic [MP-1:0]     tcdm_r_valid_i
);

  localparam int NW  = DW / 32;
  localparam int S   = NW / MP;
  localparam int SW  = (S > 1) ? $clog2(S) : 1;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [29:0]            addr_q, addr_d;
  logic [DW-1:0]          data_q, data_d;
  logic [DW/8-1:0]        be_q, be_d;
  logic                   write_q, write_d;
  logic [SW-1:0]          slice_q, slice_d;
  logic [MP-1:0]          gmask_q, gmask_d;
  logic [MP-1:0]          pend_q, pend_d;
  logic [MP-1:0][SW-1:0]  tag_q, tag_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   wr_done_q, wr_done_d;

  logic [MP-1:0]          w_gnt;
  logic [MP-1:0]          w_rv;
  logic [MP-1:0]          w_all;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr_i[1:0];

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_data_o  = rdata_q;
  assign wr_done_o   = wr_done_q;
  assign beat_cnt_o  = cnt_q;

  // Port p of slice k carries beat word k*MP+p.
  for (genvar p = 0; p < MP; p++) begin : g_port
    logic [WIW-1:0] widx;
    assign widx                    = WIW'(int'(slice_q) * MP + p);
    assign tcdm_req_o[p]           = (state_q == ST_ISSUE) && !gmask_q[p];
    assign tcdm_wen_o[p]           = !write_q;
    assign tcdm_add_o[p*32 +: 32]  = {addr_q, 2'b00} + {{(30-WIW){1'b0}}, widx, 2'b00};
    assign tcdm_be_o[p*4 +: 4]     = be_q[int'(widx)*4 +: 4];
    assign tcdm_data_o[p*32 +: 32] = data_q[int'(widx)*32 +: 32];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    write_d   = write_q;
    slice_d   = slice_q;
    gmask_d   = gmask_q;
    tag_d     = tag_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    wr_done_d = 1'b0;

    w_gnt = tcdm_gnt_i & tcdm_req_o;
    w_rv  = tcdm_r_valid_i & pend_q;
    w_all = gmask_q | w_gnt;

    // Read data lands in the word of the slice the port was granted in.
    for (int p = 0; p < MP; p++) begin
      if (w_rv[p]) begin
        rdata_d[(int'(tag_q[p]) * MP + p) * 32 +: 32] = tcdm_r_data_i[p*32 +: 32];
      end
      if (w_gnt[p]) begin
        tag_d[p] = slice_q;
      end
    end
    pend_d = (pend_q & ~w_rv) | (write_q ? '0 : w_gnt);

    case (state_q)
      ST_IDLE: begin
        pend_d = '0;
        if (req_valid_i) begin
          addr_d  = req_addr_i[31:2];
          data_d  = req_data_i;
          be_d    = req_be_i;
          write_d = req_write_i;
          slice_d = '0;
          gmask_d = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (&w_all) begin
          gmask_d = '0;
          if (slice_q == SW'(S - 1)) begin
            if (write_q) begin
              wr_done_d = 1'b1;
              cnt_d     = cnt_q + CNT_W'(1);
              state_d   = ST_IDLE;
            end else begin
              state_d = (pend_d == '0) ? ST_RESP : ST_WAIT;
            end
          end else begin
            slice_d = slice_q + SW'(1);
          end
        end else begin
          gmask_d = w_all;
        end
      end
      ST_WAIT: begin
        if (pend_d == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
      slice_q   <= '0;
      gmask_q   <= '0;
      pend_q    <= '0;
      tag_q     <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      write_q   <= write_d;
      slice_q   <= slice_d;
      gmask_q   <= gmask_d;
      pend_q    <= pend_d;
      tag_q     <= tag_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nvdla_dbb_tcdm_bridge.sv
`default_nettype none
// ============================================================================
// tb_nvdla_dbb_tcdm_bridge : scoreboard bench with a TCDM memory responder and
// a word-level reference memory for the DW=128, MP=2 configuration.
// Rev 1.0
// ============================================================================
module tb_nvdla_dbb_tcdm_bridge;

  localparam int DW    = 128;
  localparam int MP    = 2;
  localparam int CNT_W = 4;
  localparam int NW    = DW / 32;
  localparam int S     = NW / MP;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid_i, req_ready_o, req_write_i;
  logic [31:0]       req_addr_i;
  logic [DW-1:0]     req_data_i;
  logic [DW/8-1:0]   req_be_i;
  logic              rsp_valid_o, rsp_ready_i;
  logic [DW-1:0]     rsp_data_o;
  logic              wr_done_o, busy_o;
  logic [CNT_W-1:0]  beat_cnt_o;
  logic [MP-1:0]     tcdm_req_o, tcdm_gnt_i, tcdm_wen_o, tcdm_r_valid_i;
  logic [MP*32-1:0]  tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [MP*4-1:0]   tcdm_be_o;

  always #5 clk = ~clk;

  nvdla_dbb_tcdm_bridge #(.DW(DW), .MP(MP), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .wr_done_o(wr_done_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i)
  );

  typedef struct {
    bit            wr;
    logic [DW-1:0] data;
    int            t_hs;
    bit            lat;
  } exp_t;

  exp_t             sbq[$];
  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               ref_cnt = 0;
  bit               inc_pend = 0;
  bit               prev_hold = 0;
  logic [DW-1:0]    hold_data = '0;
  bit               gnt_all, rdy_rand, in_rst;
  int               hold_cnt, p1_block;
  logic [31:0]      cur_base = '0;
  logic [DW-1:0]    cur_data = '0;
  logic [DW/8-1:0]  cur_be = '0;
  bit               cur_wr = 0;
  bit [NW-1:0]      covered = '0;
  logic [MP-1:0]    rv_next = '0;
  logic [MP*32-1:0] rd_next = '0;
  bit [31:0]        slave_mem [bit [31:0]];
  bit [31:0]        ref_mem [bit [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit [31:0] dflt(input bit [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction

  function automatic bit [31:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit [31:0] slave_rd(input bit [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction

  function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] n, input bit [3:0] be);
    bit [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // Issue one beat: the reference memory is updated/read at word granularity here.
  task automatic issue(input bit wr, input logic [31:0] addr, input bit lat, input bit full_be);
    logic [DW-1:0]   d;
    logic [DW/8-1:0] be;
    logic [31:0]     a;
    exp_t            e;
    int              n = 0;
    d  = {$urandom(), $urandom(), $urandom(), $urandom()};
    be = full_be ? '1 : DW/8'($urandom());
    @(negedge clk); #2;
    while (!req_ready_o && n < 300) begin @(negedge clk); #2; n++; end
    chk(req_ready_o == 1'b1, "req_ready_wait", req_ready_o, 1);
    if (!req_ready_o) return;
    cur_base = {addr[31:2], 2'b00};
    cur_data = d;
    cur_be   = be;
    cur_wr   = wr;
    covered  = '0;
    e.wr = wr; e.data = '0; e.t_hs = cyc; e.lat = lat;
    for (int w = 0; w < NW; w++) begin
      a = cur_base + 32'(4 * w);
      if (wr) ref_mem[a] = merge(ref_rd(a), d[w*32 +: 32], be[w*4 +: 4]);
      else    e.data[w*32 +: 32] = ref_rd(a);
    end
    sbq.push_back(e);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_data_i = d; req_be_i = be;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i  = $urandom();
    req_data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk(sbq.size() == 0, "drain_timeout", sbq.size(), 0);
  endtask

  // TCDM memory responder: random grants, read data one cycle after grant.
  initial begin : slave
    logic [31:0] a, off;
    int w;
    bit ok, gg;
    tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
    forever begin
      @(negedge clk);
      tcdm_r_valid_i = rv_next;
      tcdm_r_data_i  = rd_next;
      rv_next = '0;
      rd_next = '0;
      for (int p = 0; p < MP; p++) begin
        gg = gnt_all || ($urandom_range(0, 1) == 1);
        if (p == 1 && p1_block > 0 && tcdm_req_o[1]) begin gg = 1'b0; p1_block--; end
        tcdm_gnt_i[p] = gg;
        if (gg && tcdm_req_o[p] && !in_rst) begin
          a   = tcdm_add_o[p*32 +: 32];
          off = a - cur_base;
          w   = int'(off >> 2);
          ok  = (off[1:0] == 2'b00) && (w < NW) && (w % MP == p);
          if (ok) begin
            if (covered[w]) ok = 1'b0;
            for (int j = 0; j < (w / MP) * MP; j++) if (!covered[j]) ok = 1'b0;
          end
          chk(ok, "tcdm_word_order", a, cur_base);
          chk(tcdm_wen_o[p] == !cur_wr, "tcdm_wen", tcdm_wen_o[p], !cur_wr);
          if (ok) begin
            covered[w] = 1'b1;
            if (cur_wr) begin
              chk(tcdm_data_o[p*32 +: 32] == cur_data[w*32 +: 32], "tcdm_wdata",
                  tcdm_data_o[p*32 +: 32], cur_data[w*32 +: 32]);
              chk(tcdm_be_o[p*4 +: 4] == cur_be[w*4 +: 4], "tcdm_be",
                  tcdm_be_o[p*4 +: 4], cur_be[w*4 +: 4]);
            end
          end
          if (tcdm_wen_o[p]) begin
            rv_next[p] = 1'b1;
            rd_next[p*32 +: 32] = slave_rd(a);
          end else begin
            slave_mem[a] = merge(slave_rd(a), tcdm_data_o[p*32 +: 32], tcdm_be_o[p*4 +: 4]);
          end
        end
      end
    end
  end

  initial begin : rsp_ready_drv
    rsp_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0) begin
        rsp_ready_i = 1'b0;
        if (rsp_valid_o) hold_cnt--;
      end else begin
        rsp_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk); #1;
      if (!in_rst) begin
        if (inc_pend) begin ref_cnt++; inc_pend = 0; end
        if (wr_done_o) begin
          ok = (sbq.size() > 0) && sbq[0].wr;
          chk(ok, "wr_done_expected", wr_done_o, 0);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.lat) chk(cyc == e.t_hs + S + 1, "wr_done_latency", cyc, e.t_hs + S + 1);
          end
          chk(covered == '1, "wr_all_words", covered, '1);
          ref_cnt++;
        end
        chk(beat_cnt_o == ref_cnt[CNT_W-1:0], "beat_cnt", beat_cnt_o, ref_cnt[CNT_W-1:0]);
        if (prev_hold)
          chk(rsp_valid_o && rsp_data_o == hold_data && !req_ready_o, "rsp_hold_stable", rsp_data_o, hold_data);
        if (rsp_valid_o) begin
          if (!prev_hold && sbq.size() > 0 && sbq[0].lat)
            chk(cyc == sbq[0].t_hs + S + 2, "rsp_latency", cyc, sbq[0].t_hs + S + 2);
          if (rsp_ready_i) begin
            ok = (sbq.size() > 0) && !sbq[0].wr;
            chk(ok, "rsp_expected", rsp_valid_o, 0);
            if (sbq.size() > 0) begin
              e = sbq.pop_front();
              chk(rsp_data_o == e.data, "rsp_data", rsp_data_o, e.data);
            end
            inc_pend  = 1;
            prev_hold = 0;
          end else begin
            prev_hold = 1;
            hold_data = rsp_data_o;
          end
        end else begin
          prev_hold = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    rst_i = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
    req_data_i = '0; req_be_i = '0;
    gnt_all = 1; rdy_rand = 0; hold_cnt = 0; p1_block = 0; in_rst = 1;
    for (int i = 0; i < 4; i++) begin
      slave_mem[32'h200 + 32'(4*i)] = 32'hA0 + 32'(i);
      ref_mem[32'h200 + 32'(4*i)]   = 32'hA0 + 32'(i);
    end
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #2;
    chk(req_ready_o == 1'b1, "reset_req_ready", req_ready_o, 1);
    chk({busy_o, rsp_valid_o, wr_done_o} == 3'b000, "reset_flags", {busy_o, rsp_valid_o, wr_done_o}, 0);
    chk(tcdm_req_o == '0, "reset_tcdm_req", tcdm_req_o, 0);
    chk(beat_cnt_o == '0, "reset_beat_cnt", beat_cnt_o, 0);
    in_rst = 0;

    issue(1, 32'h100, 1, 1);  wait_idle();
    issue(0, 32'h200, 1, 1);  wait_idle();
    p1_block = 3;
    issue(0, 32'h208, 0, 1);  wait_idle();
    hold_cnt = 5;
    issue(0, 32'h100, 0, 1);  wait_idle();
    issue(0, 32'hFFFF_FFF8, 1, 1); wait_idle();

    gnt_all = 0; rdy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 : 32'h0000_1000)
          + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      issue($urandom_range(0, 1) == 1, a, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

    // Reset while a read is in its first issue cycle.
    rdy_rand = 0;
    issue(0, 32'h1040, 0, 0);
    #2;
    in_rst = 1; rst_i = 1'b1;
    @(negedge clk); #2;
    chk(busy_o == 1'b0 && req_ready_o == 1'b1, "midrst_idle", busy_o, 0);
    chk(tcdm_req_o == '0, "midrst_tcdm_req", tcdm_req_o, 0);
    chk(rsp_valid_o == 1'b0 && wr_done_o == 1'b0, "midrst_rsp", rsp_valid_o, 0);
    chk(beat_cnt_o == '0, "midrst_beat_cnt", beat_cnt_o, 0);
    rst_i = 1'b0;
    sbq.delete();
    ref_cnt = 0; inc_pend = 0; prev_hold = 0;
    @(negedge clk); #2;
    in_rst = 0;
    issue(0, 32'h1000, 0, 0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
